// File: rtl/ni_flit_depacketizer.sv
// Reassembles head/body/tail NoC flits into fixed-length packets and queues
// completed packets in a small FIFO for the consumer.
module ni_flit_depacketizer #(
  parameter int FLIT_W     = 16,
  parameter int BODY_FLITS = 2,
  parameter int PKT_DEPTH  = 2
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [FLIT_W-1:0]                      i_flit,
  input  logic                                   enable,
  output logic                                   ready,
  output logic [(BODY_FLITS+2)*(FLIT_W-2)-1:0]   o_pkt,
  output logic                                   o_pkt_valid,
  input  logic                                   i_pkt_ready,
  output logic                                   o_err,
  output logic [$clog2(PKT_DEPTH+1)-1:0]         o_pkt_count
);
  localparam int PW          = FLIT_W - 2;
  localparam int TOTAL_FLITS = BODY_FLITS + 2;
  localparam int PKT_W       = TOTAL_FLITS * PW;
  localparam int CNTW        = $clog2(PKT_DEPTH + 1);
  localparam int BCW         = $clog2(BODY_FLITS + 1);
  localparam int PTRW        = (PKT_DEPTH > 1) ? $clog2(PKT_DEPTH) : 1;
  localparam logic [CNTW-1:0] DEPTH_C   = CNTW'(PKT_DEPTH);
  localparam logic [BCW-1:0]  LAST_BODY = BCW'(BODY_FLITS - 1);
  localparam logic [PTRW-1:0] LAST_PTR  = PTRW'(PKT_DEPTH - 1);
  localparam logic [1:0] T_HEAD = 2'b01, T_BODY = 2'b00, T_TAIL = 2'b10;

  typedef enum logic [1:0] {S_HEAD, S_BODY, S_TAIL} state_t;

  state_t                            r_state, w_nxt;
  logic [BCW-1:0]                    r_bcnt;
  logic [TOTAL_FLITS-2:0][PW-1:0]    r_asm;
  logic [PKT_W-1:0]                  r_buf [PKT_DEPTH];
  logic [PTRW-1:0]                   r_wr, r_rd;
  logic [CNTW-1:0]                   r_count;
  logic                              r_err;

  logic [1:0]    w_type;
  logic [PW-1:0] w_pay;
  logic          w_acc, w_pop, w_err, w_ld_head, w_ld_body, w_push;
  logic [PKT_W-1:0] w_pkt;

  assign w_type      = i_flit[FLIT_W-1 -: 2];
  assign w_pay       = i_flit[PW-1:0];
  assign ready       = (r_count < DEPTH_C);
  assign w_acc       = enable && ready;
  assign o_pkt_valid = (r_count != '0);
  assign w_pop       = o_pkt_valid && i_pkt_ready;
  assign o_pkt       = r_buf[r_rd];
  assign o_pkt_count = r_count;
  assign o_err       = r_err;

  // Head sits in the MSB slot; the tail payload is taken straight from the flit.
  for (genvar k = 0; k < TOTAL_FLITS-1; k++) begin : g_flat
    assign w_pkt[(TOTAL_FLITS-1-k)*PW +: PW] = r_asm[k];
  end
  assign w_pkt[PW-1:0] = w_pay;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_HEAD;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (w_acc) begin
      case (r_state)
        S_HEAD:  if (w_type == T_HEAD) w_nxt = S_BODY;
        S_BODY: begin
          if (w_type == T_HEAD)      w_nxt = S_BODY;
          else if (w_type == T_BODY) w_nxt = (r_bcnt == LAST_BODY) ? S_TAIL : S_BODY;
          else                       w_nxt = S_HEAD;
        end
        S_TAIL:  w_nxt = (w_type == T_HEAD) ? S_BODY : S_HEAD;
        default: w_nxt = S_HEAD;
      endcase
    end
  end

  // A head always (re)starts assembly; anything unexpected is flagged.
  always_comb begin
    w_err     = 1'b0;
    w_ld_head = 1'b0;
    w_ld_body = 1'b0;
    w_push    = 1'b0;
    if (w_acc) begin
      w_ld_head = (w_type == T_HEAD);
      case (r_state)
        S_HEAD:  w_err = (w_type != T_HEAD);
        S_BODY: begin
          w_ld_body = (w_type == T_BODY);
          w_err     = (w_type != T_BODY);
        end
        S_TAIL: begin
          w_push = (w_type == T_TAIL);
          w_err  = (w_type != T_TAIL);
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bcnt <= '0;
      r_asm  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_ld_head) begin
        r_bcnt   <= '0;
        r_asm[0] <= w_pay;
      end else if (w_ld_body) begin
        r_bcnt <= r_bcnt + 1'b1;
        for (int k = 1; k < TOTAL_FLITS-1; k++)
          if (int'(r_bcnt) + 1 == k) r_asm[k] <= w_pay;
      end
    end
  end

  // Push cannot happen while full because acceptance is gated by ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < PKT_DEPTH; i++) r_buf[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr] <= w_pkt;
        r_wr        <= (r_wr == LAST_PTR) ? '0 : r_wr + 1'b1;
      end
      if (w_pop) r_rd <= (r_rd == LAST_PTR) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_ni_flit_depacketizer.sv
// Directed bench for ni_flit_depacketizer at FLIT_W=16, BODY_FLITS=2, PKT_DEPTH=2.
module tb_ni_flit_depacketizer;
  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] i_flit;
  logic        enable;
  logic        ready;
  logic [55:0] o_pkt;
  logic        o_pkt_valid;
  logic        i_pkt_ready;
  logic        o_err;
  logic [1:0]  o_pkt_count;

  int n_cmp = 0;
  int n_fail = 0;
  int n_err = 0;
  logic [55:0] popped[$];

  ni_flit_depacketizer #(.FLIT_W(16), .BODY_FLITS(2), .PKT_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .i_flit(i_flit), .enable(enable), .ready(ready),
    .o_pkt(o_pkt), .o_pkt_valid(o_pkt_valid), .i_pkt_ready(i_pkt_ready),
    .o_err(o_err), .o_pkt_count(o_pkt_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_err === 1'b1) n_err++;
  always @(posedge clk) if (resetn && o_pkt_valid && i_pkt_ready) popped.push_back(o_pkt);

  task automatic send_flit(input logic [15:0] f);
    i_flit = f;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; enable = 1'b0; i_flit = '0; i_pkt_ready = 1'b0;
    #3;
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
    n_cmp++; if (o_pkt_valid !== 1'b0 || o_pkt_count !== 2'd0) begin n_fail++;
      $display("FAIL reset_count: got valid=%b count=%0d want 0/0", o_pkt_valid, o_pkt_count); end
    n_cmp++; if (o_err !== 1'b0 || o_pkt !== 56'd0) begin n_fail++;
      $display("FAIL reset_out: got err=%b pkt=%h want 0/0", o_err, o_pkt); end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [55:0] exp = {14'h0123, 14'h0456, 14'h0789, 14'h0ABC};
    int e0 = n_err;
    int p0 = popped.size();
    i_pkt_ready = 1'b1;
    send_flit(16'h4123); send_flit(16'h0456); send_flit(16'h0789);
    n_cmp++; if (o_pkt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got valid=%b want 0", o_pkt_valid); end
    send_flit(16'h8ABC);
    n_cmp++; if (o_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", o_pkt_valid); end
    n_cmp++; if (o_pkt !== exp) begin n_fail++; $display("FAIL basic_pkt: got %h want %h", o_pkt, exp); end
    @(posedge clk); #1;
    i_pkt_ready = 1'b0;
    n_cmp++; if (o_pkt_valid !== 1'b0 || popped.size() != p0 + 1) begin n_fail++;
      $display("FAIL basic_pop: got valid=%b pops=%0d want 0/1", o_pkt_valid, popped.size() - p0); end
    n_cmp++; if (n_err != e0) begin n_fail++; $display("FAIL basic_err: got %0d want 0", n_err - e0); end
  endtask

  task automatic test_back_to_back;
    logic [55:0] pa = {14'h0001, 14'h0002, 14'h0003, 14'h0004};
    logic [55:0] pb = {14'h0011, 14'h0012, 14'h0013, 14'h0014};
    logic [55:0] pc = {14'h0021, 14'h0022, 14'h0023, 14'h0024};
    int p0 = popped.size();
    i_pkt_ready = 1'b0;
    send_flit(16'h4001); send_flit(16'h0002); send_flit(16'h0003); send_flit(16'h8004);
    send_flit(16'h4011); send_flit(16'h0012); send_flit(16'h0013); send_flit(16'h8014);
    n_cmp++; if (o_pkt_count !== 2'd2 || ready !== 1'b0) begin n_fail++;
      $display("FAIL b2b_full: got count=%0d ready=%b want 2/0", o_pkt_count, ready); end
    i_flit = 16'h4021; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_pkt_count !== 2'd2 || o_pkt !== pa) begin n_fail++;
      $display("FAIL b2b_stall: got count=%0d pkt=%h want 2/%h", o_pkt_count, o_pkt, pa); end
    i_pkt_ready = 1'b1;
    @(posedge clk); #1;
    i_pkt_ready = 1'b0;
    n_cmp++; if (o_pkt_count !== 2'd1 || ready !== 1'b1 || o_pkt !== pb) begin n_fail++;
      $display("FAIL b2b_pop1: got count=%0d ready=%b pkt=%h want 1/1/%h", o_pkt_count, ready, o_pkt, pb); end
    send_flit(16'h4021); send_flit(16'h0022); send_flit(16'h0023); send_flit(16'h8024);
    n_cmp++; if (o_pkt_count !== 2'd2 || o_pkt !== pb) begin n_fail++;
      $display("FAIL b2b_third: got count=%0d pkt=%h want 2/%h", o_pkt_count, o_pkt, pb); end
    i_pkt_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_pkt !== pc || o_pkt_count !== 2'd1) begin n_fail++;
      $display("FAIL b2b_pop2: got count=%0d pkt=%h want 1/%h", o_pkt_count, o_pkt, pc); end
    @(posedge clk); #1;
    i_pkt_ready = 1'b0;
    n_cmp++; if (o_pkt_valid !== 1'b0 || popped.size() != p0 + 3) begin n_fail++;
      $display("FAIL b2b_drain: got valid=%b pops=%0d want 0/3", o_pkt_valid, popped.size() - p0); end
    n_cmp++; if (popped.size() == p0 + 3 && (popped[p0] !== pa || popped[p0+1] !== pb || popped[p0+2] !== pc)) begin
      n_fail++; $display("FAIL b2b_order: got %h %h %h want %h %h %h",
                         popped[p0], popped[p0+1], popped[p0+2], pa, pb, pc); end
  endtask

  task automatic test_head_restart;
    logic [55:0] exp = {14'h0333, 14'h0444, 14'h0555, 14'h0666};
    int e0 = n_err;
    send_flit(16'h4111); send_flit(16'h0222);
    send_flit(16'h4333);
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL restart_err: got %b want 1", o_err); end
    send_flit(16'h0444); send_flit(16'h0555); send_flit(16'h8666);
    n_cmp++; if (o_pkt_count !== 2'd1 || o_pkt !== exp) begin n_fail++;
      $display("FAIL restart_pkt: got count=%0d pkt=%h want 1/%h", o_pkt_count, o_pkt, exp); end
    n_cmp++; if (n_err != e0 + 1) begin n_fail++; $display("FAIL restart_errcnt: got %0d want 1", n_err - e0); end
    i_pkt_ready = 1'b1; @(posedge clk); #1; i_pkt_ready = 1'b0;
  endtask

  task automatic test_wrong_type;
    logic [55:0] exp = {14'h0031, 14'h0032, 14'h0033, 14'h0034};
    int e0 = n_err;
    send_flit(16'h0222);
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL wrong_body_err: got %b want 1", o_err); end
    send_flit(16'h4100); send_flit(16'h0200);
    n_cmp++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL wrong_clean: got %b want 0", o_err); end
    send_flit(16'h8777);
    n_cmp++; if (o_err !== 1'b1 || o_pkt_count !== 2'd0) begin n_fail++;
      $display("FAIL wrong_tail: got err=%b count=%0d want 1/0", o_err, o_pkt_count); end
    send_flit(16'hC000);
    n_cmp++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL wrong_rsvd: got %b want 1", o_err); end
    send_flit(16'h4031); send_flit(16'h0032); send_flit(16'h0033); send_flit(16'h8034);
    n_cmp++; if (o_pkt !== exp || o_pkt_count !== 2'd1 || n_err != e0 + 3) begin n_fail++;
      $display("FAIL wrong_recover: got pkt=%h count=%0d errs=%0d want %h/1/3", o_pkt, o_pkt_count, n_err - e0, exp); end
    i_pkt_ready = 1'b1; @(posedge clk); #1; i_pkt_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [55:0] exp = {14'h0061, 14'h0062, 14'h0063, 14'h0064};
    int e0 = n_err;
    send_flit(16'h4041); send_flit(16'h0042); send_flit(16'h0043); send_flit(16'h8044);
    send_flit(16'h4051); send_flit(16'h0052);
    resetn = 1'b0;
    #1;
    n_cmp++; if (o_pkt_count !== 2'd0 || o_pkt_valid !== 1'b0 || o_pkt !== 56'd0 || ready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_async: got count=%0d valid=%b pkt=%h ready=%b want 0/0/0/1", o_pkt_count, o_pkt_valid, o_pkt, ready); end
    @(posedge clk); #1 resetn = 1'b1;
    send_flit(16'h4061); send_flit(16'h0062); send_flit(16'h0063); send_flit(16'h8064);
    n_cmp++; if (o_pkt_count !== 2'd1 || o_pkt !== exp || n_err != e0) begin n_fail++;
      $display("FAIL rstmid_pkt: got count=%0d pkt=%h errs=%0d want 1/%h/0", o_pkt_count, o_pkt, n_err - e0, exp); end
    i_pkt_ready = 1'b1; @(posedge clk); #1; i_pkt_ready = 1'b0;
  endtask

  task automatic test_full_refill;
    logic [55:0] p1 = {14'h0071, 14'h0072, 14'h0073, 14'h0074};
    logic [55:0] p2 = {14'h0081, 14'h0082, 14'h0083, 14'h0084};
    logic [55:0] p3 = {14'h0091, 14'h0092, 14'h0093, 14'h0094};
    int p0 = popped.size();
    int e0 = n_err;
    send_flit(16'h4071); send_flit(16'h0072); send_flit(16'h0073); send_flit(16'h8074);
    send_flit(16'h4081); send_flit(16'h0082); send_flit(16'h0083); send_flit(16'h8084);
    i_pkt_ready = 1'b1; i_flit = 16'h4091; enable = 1'b1;
    @(posedge clk); #1;
    i_pkt_ready = 1'b0;
    n_cmp++; if (o_pkt_count !== 2'd1 || ready !== 1'b1 || o_pkt !== p2) begin n_fail++;
      $display("FAIL full_pop: got count=%0d ready=%b pkt=%h want 1/1/%h", o_pkt_count, ready, o_pkt, p2); end
    @(posedge clk); #1;
    enable = 1'b0;
    send_flit(16'h0092); send_flit(16'h0093);
    i_pkt_ready = 1'b1;
    send_flit(16'h8094);
    n_cmp++; if (o_pkt_count !== 2'd1 || o_pkt !== p3) begin n_fail++;
      $display("FAIL full_pushpop: got count=%0d pkt=%h want 1/%h", o_pkt_count, o_pkt, p3); end
    @(posedge clk); #1;
    i_pkt_ready = 1'b0;
    n_cmp++; if (o_pkt_count !== 2'd0 || popped.size() != p0 + 3 || n_err != e0) begin n_fail++;
      $display("FAIL full_drain: got count=%0d pops=%0d errs=%0d want 0/3/0", o_pkt_count, popped.size() - p0, n_err - e0); end
    n_cmp++; if (popped.size() == p0 + 3 && (popped[p0] !== p1 || popped[p0+1] !== p2 || popped[p0+2] !== p3)) begin
      n_fail++; $display("FAIL full_order: got %h %h %h want %h %h %h",
                         popped[p0], popped[p0+1], popped[p0+2], p1, p2, p3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_head_restart();
    test_wrong_type();
    test_reset_mid();
    test_full_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ni_flit_depacketizer.md
NI_FLIT_DEPACKETIZER -- requirements
Module: ni_flit_depacketizer

Interface
REQ-001 Parameter FLIT_W, default 16, flit width in bits; bits [FLIT_W-1:FLIT_W-2] are flit type, the rest are payload (PW = FLIT_W-2).
REQ-002 Parameter BODY_FLITS, default 2, body flits per packet; TOTAL_FLITS = BODY_FLITS+2; legal range 1..16.
REQ-003 Parameter PKT_DEPTH, default 2, assembled-packet buffer depth; legal range 1..8.
REQ-004 Flit types SHALL be: 2'b01 head, 2'b00 body, 2'b10 tail; 2'b11 reserved (illegal).
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 i_flit  input  FLIT_W  flit from NoC.
REQ-008 enable  input  1  i_flit valid this cycle.
REQ-009 ready  output  1  block can accept a flit this cycle.
REQ-010 o_pkt  output  TOTAL_FLITS*PW  assembled payload; head payload in MSBs, tail payload in LSBs.
REQ-011 o_pkt_valid  output  1  o_pkt holds a complete packet.
REQ-012 i_pkt_ready  input  1  consumer accepts o_pkt.
REQ-013 o_err  output  1  one-cycle pulse on protocol violation.
REQ-014 o_pkt_count  output  $clog2(PKT_DEPTH+1)  packets held in buffer.

Function
REQ-015 A flit SHALL be accepted on posedge clk iff enable && ready; when not accepted, i_flit SHALL be ignored with no state change.
REQ-016 ready SHALL equal (o_pkt_count < PKT_DEPTH), combinational from registered count only; a same-cycle pop SHALL NOT raise ready.
REQ-017 Assembly FSM states: S_HEAD, S_BODY, S_TAIL; body counter SHALL count 0..BODY_FLITS-1.
REQ-018 S_HEAD: accepted head -> store payload in slot 0, clear counter, go S_BODY; any other type -> o_err, discard, stay S_HEAD.
REQ-019 S_BODY: accepted body -> store in slot counter+1, increment; after the BODY_FLITS-th body go S_TAIL.
REQ-020 S_TAIL: accepted tail -> push assembled packet (tail in last slot) into buffer, go S_HEAD.
REQ-021 In S_BODY/S_TAIL an accepted head SHALL pulse o_err, drop the partial packet, and restart assembly with that head (go S_BODY, counter 0).
REQ-022 In S_BODY/S_TAIL an accepted body/tail/reserved flit of the wrong type SHALL pulse o_err, drop the partial packet, go S_HEAD.
REQ-023 o_err SHALL be registered: high exactly the cycle after the offending edge.
REQ-024 Buffer SHALL be FIFO order with wrapping read/write pointers modulo PKT_DEPTH.
REQ-025 o_pkt_valid SHALL equal (o_pkt_count != 0); o_pkt SHALL present the oldest packet, stable while o_pkt_valid && !i_pkt_ready.
REQ-026 Pop SHALL occur on posedge when o_pkt_valid && i_pkt_ready.
REQ-027 Latency: tail accepted at edge N -> o_pkt_valid high from edge N (visible cycle N+1) when the buffer was empty.
REQ-028 Simultaneous push and pop SHALL leave o_pkt_count unchanged and advance both pointers.
REQ-029 Push never occurs when full, guaranteed by REQ-016; no overflow path exists.

Reset
REQ-030 resetn low SHALL immediately force: FSM S_HEAD, counter 0, pointers 0, o_pkt_count 0, o_pkt_valid 0, o_err 0, o_pkt all zeros, ready 1.
REQ-031 Reset mid-packet SHALL discard the partial packet and all buffered packets without o_err.

Verification (FLIT_W=16, BODY_FLITS=2, PKT_DEPTH=2)
REQ-032 Flits 0x4123,0x0456,0x0789,0x8ABC on 4 consecutive enabled cycles, i_pkt_ready=1 -> o_pkt_valid one cycle after tail edge, o_pkt = {14'h0123,14'h0456,14'h0789,14'h0ABC}, o_err 0.
REQ-033 Three back-to-back packets, i_pkt_ready=0 -> o_pkt_count reaches 2, ready falls to 0 after second tail; third packet stalls until first i_pkt_ready pulse, then completes; packets pop in order.
REQ-034 Flits 0x4111,0x0222,0x4333,0x0444,0x0555,0x8666 -> o_err pulse once after third flit; single packet {0x0333,0x0444,0x0555,0x0666}.
REQ-035 Body 0x0222 in S_HEAD, then tail 0x8777 after head+1 body -> o_err pulse each time, no packet emitted, FSM returns S_HEAD.
REQ-036 resetn low after head+body, then full valid packet -> no o_err, only the post-reset packet delivered.
REQ-037 Full buffer with i_pkt_ready=1 and a tail arriving the cycle ready rises -> count stays correct, no packet lost or duplicated.
